seg7_reg_viewer: RTL

//  Downstream consumer of the processor's register-file diagnostic port (dispSel/dispDat) on the Nexys2 board.

---
 rtl/seg7_reg_viewer_pkg.sv | 9 +
 rtl/seg7_reg_viewer_if.sv | 7 +
 rtl/seg7_reg_viewer_btn_debounce.sv | 33 +++
 rtl/seg7_reg_viewer.sv | 71 +++++++
 4 files changed

// File: rtl/seg7_reg_viewer_pkg.sv
// seg7_reg_viewer_pkg: shared display constants and the active-low hex glyph table
package seg7_reg_viewer_pkg;
    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
endpackage

// File: rtl/seg7_reg_viewer_if.sv
// seg7_reg_viewer_if: register-file diagnostic read port (address out, data back)
interface seg7_reg_viewer_if;
    logic [4:0]  dispSel;
    logic [31:0] dispDat;
    modport master (output dispSel, input dispDat);
    modport slave  (input dispSel, output dispDat);
endinterface

// File: rtl/seg7_reg_viewer_btn_debounce.sv
// btn_debounce: synchronise a raw pushbutton, accept a level after it holds stable, pulse on press
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk50MHz,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYC);
    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;
    // count consecutive cycles the synced input disagrees with the accepted level; accept on the last one
    always_ff @(posedge clk50MHz or posedge reset)
        if (reset) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            press <= 1'b0;
            if (sync[1] == level)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                level <= sync[1];
                cnt   <= '0;
                press <= sync[1];
            end else
                cnt <= cnt + 1'b1;
        end
endmodule

// File: rtl/seg7_reg_viewer.sv
// seg7_reg_viewer: browse register-file/PC words as 4 hex digits on the multiplexed 7-seg display
module seg7_reg_viewer
    import seg7_reg_viewer_pkg::*;
#(
    parameter int REFRESH_DIV  = 12500,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic                     clk50MHz,
    input  logic                     reset,
    input  logic                     btn_next,
    input  logic                     btn_prev,
    input  logic                     sw_half,
    input  logic                     sw_src,
    input  logic [31:0]              pc_in,
    seg7_reg_viewer_if.master        diag,
    output logic [3:0]               an,
    output logic [6:0]               seg,
    output logic                     dp
);
    localparam int RW = $clog2(REFRESH_DIV);
    logic [RW-1:0] cnt;
    logic [1:0]    idx;
    logic [31:0]   snap, word, src;
    logic [15:0]   half;
    logic [3:0]    nib;
    logic          tick, nxt_p, prv_p;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_next (
        .clk50MHz(clk50MHz), .reset(reset), .btn(btn_next), .press(nxt_p));
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_prev (
        .clk50MHz(clk50MHz), .reset(reset), .btn(btn_prev), .press(prv_p));

    // digit 0 reads the live word so the frame it starts matches the snapshot taken with it
    always_comb begin
        word = sw_src ? pc_in : diag.dispDat;
        src  = (idx == 2'd0) ? word : snap;
        half = sw_half ? src[31:16] : src[15:0];
        nib  = half[{idx, 2'b00} +: 4];
        tick = (cnt == RW'(REFRESH_DIV - 1));
    end

    // step the selected register; opposing presses in one cycle cancel
    always_ff @(posedge clk50MHz or posedge reset)
        if (reset)
            diag.dispSel <= '0;
        else if (nxt_p && !prv_p)
            diag.dispSel <= diag.dispSel + 5'd1;
        else if (prv_p && !nxt_p)
            diag.dispSel <= diag.dispSel - 5'd1;

    // refresh divider, digit scan, frame snapshot and registered display outputs
    always_ff @(posedge clk50MHz or posedge reset)
        if (reset) begin
            cnt  <= '0;
            idx  <= '0;
            snap <= '0;
            an   <= AN_OFF;
            seg  <= SEG_OFF;
            dp   <= 1'b1;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx <= idx + 2'd1;
                an  <= ~(4'b0001 << idx);
                seg <= SEG_HEX[nib];
                dp  <= ~(sw_half && idx == 2'd3);
                if (idx == 2'd0)
                    snap <= word;
            end
        end
endmodule
